// File: rtl/eth_ctrl_pkg.sv
// Shared MAC-control constants for the PAUSE receive path: reserved
// multicast address, EtherType/opcode values, header byte offsets and
// the receive FSM state encoding.
package eth_ctrl_pkg;

    localparam logic [47:0] PAUSE_DA         = 48'h0180C2000001;
    localparam logic [15:0] ETHTYPE_MAC_CTRL = 16'h8808;
    localparam logic [15:0] OPCODE_PAUSE     = 16'h0001;

    // Byte offsets from the first DA byte (no preamble/SFD on the bus).
    localparam logic [4:0] OFF_DA_LAST   = 5'd5;
    localparam logic [4:0] OFF_ETYPE_HI  = 5'd12;
    localparam logic [4:0] OFF_ETYPE_LO  = 5'd13;
    localparam logic [4:0] OFF_OPC_HI    = 5'd14;
    localparam logic [4:0] OFF_OPC_LO    = 5'd15;
    localparam logic [4:0] OFF_QUANTA_HI = 5'd16;
    localparam logic [4:0] OFF_QUANTA_LO = 5'd17;
    localparam logic [4:0] OFF_SAT       = 5'd18;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR       = 3'd1,
        ST_SKIP      = 3'd2,
        ST_DROP      = 3'd3,
        ST_WAIT_STAT = 3'd4
    } rx_state_t;

    // Byte 'off' (0 = most significant) of a MAC address, wire order.
    function automatic logic [7:0] mac_byte(input logic [47:0] addr,
                                            input logic [4:0]  off);
        logic [47:0] w_shifted;
        w_shifted = addr << {off, 3'b000};
        return w_shifted[47:40];
    endfunction

endpackage

// File: rtl/pause_timer.sv
// Pause quanta countdown. A load always wins over a same-cycle decrement:
// the new quanta value is taken as-is and the quantum cycle counter restarts.
module pause_timer #(
    parameter int QUANTA_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] quanta,
    output logic [15:0] quanta_rem,
    output logic        active
);

    localparam int                CYC_W    = (QUANTA_CYCLES > 2) ? $clog2(QUANTA_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(QUANTA_CYCLES - 1);

    logic [CYC_W-1:0] r_cycle_cnt;
    logic [15:0]      r_quanta_rem;

    // Load new quanta, otherwise count cycles and retire one quantum per wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quanta_rem <= 16'd0;
            r_cycle_cnt  <= '0;
        end else if (load) begin
            r_quanta_rem <= quanta;
            r_cycle_cnt  <= '0;
        end else if (r_quanta_rem != 16'd0) begin
            if (r_cycle_cnt == CYC_LAST) begin
                r_cycle_cnt  <= '0;
                r_quanta_rem <= r_quanta_rem - 16'd1;
            end else begin
                r_cycle_cnt  <= r_cycle_cnt + CYC_W'(1);
            end
        end
    end

    assign quanta_rem = r_quanta_rem;
    assign active     = (r_quanta_rem != 16'd0);

endmodule

// File: rtl/pause_frame_rx.sv
// Snoops the MAC receive byte stream for IEEE 802.3x PAUSE frames and, on
// a good-FCS match, loads the advertised quanta into the pause timer that
// holds off the local transmitter.
module pause_frame_rx
    import eth_ctrl_pkg::*;
#(
    parameter int          QUANTA_CYCLES  = 64,
    parameter logic [47:0] STATION_ADDR   = 48'h0,
    parameter bit          ACCEPT_UNICAST = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    input  logic        rx_stat_valid,
    input  logic        rx_stat_good,
    output logic        pause_active,
    output logic [15:0] pause_quanta_rem,
    output logic        pause_load,
    output logic [15:0] pause_frame_cnt
);

    rx_state_t   r_state;
    logic [4:0]  r_byte_cnt;
    logic        r_da_pause;
    logic        r_da_station;
    logic        r_type_ok;
    logic [15:0] r_quanta_cand;
    logic        r_load;
    logic [15:0] r_frame_cnt;

    logic        w_frame_start;
    logic        w_in_da;
    logic        w_in_type;
    logic [7:0]  w_exp_type;
    logic        w_match;
    logic        w_apply;
    logic        w_active;
    logic [15:0] w_quanta_rem;

    assign w_frame_start = (r_byte_cnt == 5'd0);
    assign w_in_da       = (r_byte_cnt <= OFF_DA_LAST);
    assign w_match       = (r_da_pause | (ACCEPT_UNICAST & r_da_station)) & r_type_ok;
    assign w_apply       = (r_state == ST_WAIT_STAT) && rx_stat_valid && rx_stat_good;

    // Expected EtherType/opcode byte for the current header offset.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        w_exp_type = 8'h00;
        w_in_type  = 1'b0;
        case (r_byte_cnt)
            OFF_ETYPE_HI: begin w_exp_type = ETHTYPE_MAC_CTRL[15:8]; w_in_type = 1'b1; end
            OFF_ETYPE_LO: begin w_exp_type = ETHTYPE_MAC_CTRL[7:0];  w_in_type = 1'b1; end
            OFF_OPC_HI:   begin w_exp_type = OPCODE_PAUSE[15:8];     w_in_type = 1'b1; end
            OFF_OPC_LO:   begin w_exp_type = OPCODE_PAUSE[7:0];      w_in_type = 1'b1; end
            default:      ;
        endcase
    end

    // Byte offset counter: counts valid bytes, saturates past the header.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_cnt <= 5'd0;
        end else if (rx_valid) begin
            if (rx_last) begin
                r_byte_cnt <= 5'd0;
            end else if (r_byte_cnt != OFF_SAT) begin
                r_byte_cnt <= r_byte_cnt + 5'd1;
            end
        end
    end

    // Header match flags and candidate quanta capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_da_pause    <= 1'b0;
            r_da_station  <= 1'b0;
            r_type_ok     <= 1'b0;
            r_quanta_cand <= 16'd0;
        end else if (rx_valid) begin
            // The DA flags start fresh on offset 0 and only ever fall after that.
            if (w_in_da) begin
                r_da_pause   <= (w_frame_start | r_da_pause) &
                                (rx_data == mac_byte(PAUSE_DA, r_byte_cnt));
                r_da_station <= (w_frame_start | r_da_station) &
                                (rx_data == mac_byte(STATION_ADDR, r_byte_cnt));
            end
            if (w_frame_start) begin
                r_type_ok <= 1'b1;
            end else if (w_in_type) begin
                r_type_ok <= r_type_ok & (rx_data == w_exp_type);
            end
            if (r_byte_cnt == OFF_QUANTA_HI) r_quanta_cand[15:8] <= rx_data;
            if (r_byte_cnt == OFF_QUANTA_LO) r_quanta_cand[7:0]  <= rx_data;
        end
    end

    // Frame-level FSM with registered apply strobe and accepted-frame count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_load      <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            // NOTE: non-blocking so every register here sees pre-edge values.
            r_load <= w_apply;
            if (w_apply && (r_frame_cnt != 16'hFFFF)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid && !rx_last) r_state <= ST_HDR;
                end
                ST_HDR: begin
                    if (rx_valid) begin
                        if (r_byte_cnt == OFF_QUANTA_LO) begin
                            if (rx_last) r_state <= w_match ? ST_WAIT_STAT : ST_IDLE;
                            else         r_state <= w_match ? ST_SKIP : ST_DROP;
                        end else if (rx_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_SKIP: begin
                    if (rx_valid && rx_last) r_state <= ST_WAIT_STAT;
                end
                ST_DROP: begin
                    if (rx_valid && rx_last) r_state <= ST_IDLE;
                end
                ST_WAIT_STAT: begin
                    // A new frame without status abandons the candidate; its
                    // first byte has already been counted as offset 0.
                    if (rx_valid) begin
                        r_state <= rx_last ? ST_IDLE : ST_HDR;
                    end else if (rx_stat_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    pause_timer #(
        .QUANTA_CYCLES (QUANTA_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (w_apply),
        .quanta     (r_quanta_cand),
        .quanta_rem (w_quanta_rem),
        .active     (w_active)
    );

    assign pause_active     = w_active;
    assign pause_quanta_rem = w_quanta_rem;
    assign pause_load       = r_load;
    assign pause_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_pause_frame_rx.sv
// Directed bench for pause_frame_rx with the default 64-cycle quantum.
module tb_pause_frame_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_last;
    logic        rx_stat_valid;
    logic        rx_stat_good;
    logic        pause_active;
    logic [15:0] pause_quanta_rem;
    logic        pause_load;
    logic [15:0] pause_frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int dur;

    localparam logic [47:0] DA_PAUSE = 48'h0180C2000001;

    pause_frame_rx dut (
        .clk              (clk),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_last          (rx_last),
        .rx_stat_valid    (rx_stat_valid),
        .rx_stat_good     (rx_stat_good),
        .pause_active     (pause_active),
        .pause_quanta_rem (pause_quanta_rem),
        .pause_load       (pause_load),
        .pause_frame_cnt  (pause_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a frame, one byte per cycle; optional one-cycle valid gap after
    // byte 8. stat_mode: 0 = no status, 1 = good, 2 = bad. Returns one
    // cycle after the status strobe (i.e. just after the apply edge).
    task automatic send_frame(input logic [47:0] da, input logic [15:0] et,
                              input logic [15:0] op, input logic [15:0] q,
                              input int len, input int stat_mode, input bit gap);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            if (i < 6)       b = da[47-8*i -: 8];
            else if (i < 12) b = 8'(8'h10 + i);
            else if (i == 12) b = et[15:8];
            else if (i == 13) b = et[7:0];
            else if (i == 14) b = op[15:8];
            else if (i == 15) b = op[7:0];
            else if (i == 16) b = q[15:8];
            else if (i == 17) b = q[7:0];
            else             b = 8'h00;
            if (gap && i == 8) begin
                @(posedge clk); #1;
                rx_valid = 1'b0;
                rx_last  = 1'b0;
            end
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = b;
            rx_last  = (i == len - 1);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_data  = 8'h00;
        if (stat_mode != 0) begin
            rx_stat_valid = 1'b1;
            rx_stat_good  = (stat_mode == 1);
            @(posedge clk); #1;
            rx_stat_valid = 1'b0;
            rx_stat_good  = 1'b0;
        end
    endtask

    // Count cycles pause_active stays high from now, bounded.
    task automatic measure_active(output int n);
        n = 0;
        while (pause_active === 1'b1 && n < 5000) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_last = 1'b0;
        rx_stat_valid = 1'b0; rx_stat_good = 1'b0;
        step(3);
        check("rst_active", pause_active, 0);
        check("rst_rem",    pause_quanta_rem, 0);
        check("rst_load",   pause_load, 0);
        check("rst_cnt",    pause_frame_cnt, 0);
        reset = 1'b0;
        step(2);

        // Good PAUSE, quanta 3 -> 192 active cycles.
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0003, 20, 1, 0);
        check("q3_load",   pause_load, 1);
        check("q3_rem",    pause_quanta_rem, 3);
        check("q3_active", pause_active, 1);
        check("q3_cnt",    pause_frame_cnt, 1);
        measure_active(dur);
        check("q3_duration", dur, 192);
        check("q3_rem_end",  pause_quanta_rem, 0);
        check("q3_load_end", pause_load, 0);

        // Quanta 50 then quanta 0 clears immediately.
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0032, 20, 1, 0);
        check("q50_rem", pause_quanta_rem, 50);
        step(1);
        check("q50_load_pulse", pause_load, 0);
        check("q50_active",     pause_active, 1);
        step(20);
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0000, 20, 1, 0);
        check("q0_load",   pause_load, 1);
        check("q0_active", pause_active, 0);
        check("q0_rem",    pause_quanta_rem, 0);
        check("q0_cnt",    pause_frame_cnt, 3);

        // Non-PAUSE frames with good status.
        send_frame(DA_PAUSE, 16'h0800, 16'h0001, 16'h0005, 20, 1, 0);
        check("etype_load", pause_load, 0);
        check("etype_cnt",  pause_frame_cnt, 3);
        send_frame(DA_PAUSE, 16'h8808, 16'h0002, 16'h0005, 20, 1, 0);
        check("opcode_load", pause_load, 0);
        check("opcode_cnt",  pause_frame_cnt, 3);
        send_frame(48'h0180C2000002, 16'h8808, 16'h0001, 16'h0005, 20, 1, 0);
        check("da_load",   pause_load, 0);
        check("da_rem",    pause_quanta_rem, 0);
        check("da_cnt",    pause_frame_cnt, 3);

        // Bad FCS, then a short frame ending at offset 16.
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0005, 20, 2, 0);
        check("badfcs_load",   pause_load, 0);
        check("badfcs_active", pause_active, 0);
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0005, 17, 1, 0);
        check("short_load",   pause_load, 0);
        check("short_active", pause_active, 0);
        check("short_cnt",    pause_frame_cnt, 3);

        // Refresh mid-pause (first frame has a valid gap).
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0010, 20, 1, 1);
        check("q16_rem", pause_quanta_rem, 16);
        check("q16_cnt", pause_frame_cnt, 4);
        step(100);
        check("q16_rem_100", pause_quanta_rem, 15);
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0002, 20, 1, 0);
        check("refresh_rem", pause_quanta_rem, 2);
        check("refresh_cnt", pause_frame_cnt, 5);
        measure_active(dur);
        check("refresh_duration", dur, 128);

        // Candidate abandoned by a new frame arriving before status.
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0009, 20, 0, 0);
        check("nostat_load", pause_load, 0);
        check("nostat_rem",  pause_quanta_rem, 0);
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0004, 20, 1, 0);
        check("b2b_rem", pause_quanta_rem, 4);
        check("b2b_cnt", pause_frame_cnt, 6);

        // Apply coincident with a quantum wrap: 64 edges after the q=5 apply.
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0005, 20, 1, 0);
        check("q5_rem", pause_quanta_rem, 5);
        step(42);
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0007, 20, 1, 0);
        check("coinc_load", pause_load, 1);
        check("coinc_rem",  pause_quanta_rem, 7);
        measure_active(dur);
        check("coinc_duration", dur, 448);
        check("coinc_cnt", pause_frame_cnt, 8);

        // Reset during a pause.
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0003, 20, 1, 0);
        check("pre_rst_cnt", pause_frame_cnt, 9);
        step(10);
        #2 reset = 1'b1;
        #1;
        check("rst_pause_active", pause_active, 0);
        check("rst_pause_rem",    pause_quanta_rem, 0);
        check("rst_pause_cnt",    pause_frame_cnt, 0);
        check("rst_pause_load",   pause_load, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Reset in the middle of a header.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = DA_PAUSE[47-8*i -: 8];
        end
        #2 reset = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        check("rst_hdr_active", pause_active, 0);
        check("rst_hdr_cnt",    pause_frame_cnt, 0);
        @(posedge clk); #1 reset = 1'b0;
        step(2);
        send_frame(DA_PAUSE, 16'h8808, 16'h0001, 16'h0001, 20, 1, 0);
        check("post_rst_load", pause_load, 1);
        check("post_rst_cnt",  pause_frame_cnt, 1);
        check("post_rst_rem",  pause_quanta_rem, 1);
        measure_active(dur);
        check("post_rst_duration", dur, 64);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
